fifo_axis_reader: RTL

- Drain stage downstream of the synchronous FIFO. Converts the FIFO's pop/empty read port, with data returning READ_LATENCY cycles after pop, into an AXI-Stream master with valid/ready backpressure.
- Pops are credit-based against a small internal output buffer, so read data is never dropped and throughput is one beat per clock.
- Optionally marks packet boundaries with tlast every N accepted beats.

---
 rtl/fifo_axis_reader.sv | 104 ++++++++++
 1 files changed

// File: rtl/fifo_axis_reader.sv
// Drains a fixed-latency FIFO read port into an AXI-Stream master.
// Pops are credit-limited against a small output buffer; tlast marks every pkt_len beats.
module fifo_axis_reader #(
   parameter int unsigned  DATA_WIDTH   = 32,
   parameter int unsigned  READ_LATENCY = 1,
   parameter int unsigned  LEN_WIDTH    = 16,
   localparam int unsigned OBUF_DEPTH   = READ_LATENCY + 2,
   localparam int unsigned CNT_W        = $clog2(OBUF_DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   input  logic                  fifo_empty_i,
   output logic                  fifo_pop_o,
   output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
   output logic                  m_axis_tvalid_o,
   input  logic                  m_axis_tready_i,
   output logic                  m_axis_tlast_o,
   input  logic [LEN_WIDTH-1:0]  pkt_len_i,
   output logic [CNT_W-1:0]      obuf_cnt_o
);

   localparam int unsigned PTR_W = $clog2(OBUF_DEPTH);
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [CNT_W-1:0]      obuf_cnt;
   logic [CNT_W-1:0]      inflight_cnt;
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [DATA_WIDTH-1:0] obuf [OBUF_DEPTH];
   logic                  wr_en;
   logic                  hs;
   logic [LEN_WIDTH-1:0]  beat_cnt;
   logic [LEN_WIDTH-1:0]  pkt_len_q;

   // Credit check uses only registered occupancy, so tready never reaches pop combinationally.
   assign fifo_pop_o = !rst_i && !fifo_empty_i &&
                       ((SUM_W'(obuf_cnt) + SUM_W'(inflight_cnt)) < SUM_W'(OBUF_DEPTH));

   if (READ_LATENCY == 0) begin : g_no_pipe
      assign wr_en        = fifo_pop_o;
      assign inflight_cnt = '0;
   end else begin : g_pipe
      logic [READ_LATENCY-1:0] pipe;

      // Bit 0 is the newest pop; the MSB marks data arriving this cycle.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) pipe <= '0;
         else       pipe <= READ_LATENCY'({pipe, fifo_pop_o});
      end

      assign inflight_cnt = CNT_W'($countones(pipe));
      assign wr_en        = pipe[READ_LATENCY-1];
   end

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign m_axis_tvalid_o = (obuf_cnt != '0);
   assign m_axis_tdata_o  = obuf[head];
   assign obuf_cnt_o      = obuf_cnt;
   assign hs              = m_axis_tvalid_o && m_axis_tready_i;

   // Circular output buffer; head entry drives the stream.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head     <= '0;
         tail     <= '0;
         obuf_cnt <= '0;
         for (int unsigned i = 0; i < OBUF_DEPTH; i++) obuf[i] <= '0;
      end else begin
         if (wr_en) begin
            obuf[tail] <= fifo_data_i;
            tail       <= ptr_inc(tail);
         end
         if (hs) head <= ptr_inc(head);
         case ({wr_en, hs})
            2'b10:   obuf_cnt <= obuf_cnt + CNT_W'(1);
            2'b01:   obuf_cnt <= obuf_cnt - CNT_W'(1);
            default: obuf_cnt <= obuf_cnt;
         endcase
      end
   end

   assign m_axis_tlast_o = m_axis_tvalid_o && (pkt_len_q != '0) &&
                           (beat_cnt == pkt_len_q - LEN_WIDTH'(1));

   // Packet length is sampled only between packets so a mid-packet change takes effect next packet.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         beat_cnt  <= '0;
         pkt_len_q <= '0;
      end else begin
         if (hs) beat_cnt <= m_axis_tlast_o ? '0 : beat_cnt + LEN_WIDTH'(1);
         if ((beat_cnt == '0 && !m_axis_tvalid_o) || (hs && m_axis_tlast_o))
            pkt_len_q <= pkt_len_i;
      end
   end

   obuf_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
                                      !(wr_en && obuf_cnt == CNT_W'(OBUF_DEPTH)));

endmodule
